vga_timing_gen: RTL

Generates pixel coordinates and VGA sync for the display path. Drives `pixelX`/`pixelY` into every drawing object (words, letters, squares, ball, flippers). Takes the final 8-bit RRRGGGBB colour back from the object mux, blanks it outside the active area, and expands it to 8-bit-per-channel DAC outputs. Sync and blank are delayed so they align with the colour produced by the drawing pipeline.

---
 rtl/vga_timing_gen_pkg.sv | 38 +++
 rtl/vga_timing_gen_delay_line.sv | 49 ++++
 rtl/vga_timing_gen.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : defines (package)
// Purpose  : Shared VGA display constants and colour helpers.
//            - Default 640x480@60 timing constants, used as parameter defaults.
//            - Pixel coordinate width.
//            - RRRGGGBB -> 24-bit colour expansion, shared by every colour
//              consumer so that all of them expand the same way.
// Revision : 1.0 - initial release
// ============================================================================
package defines;

  localparam int c_H_ACTIVE = 640;
  localparam int c_H_FP     = 16;
  localparam int c_H_SYNC   = 96;
  localparam int c_H_BP     = 48;
  localparam int c_V_ACTIVE = 480;
  localparam int c_V_FP     = 10;
  localparam int c_V_SYNC   = 2;
  localparam int c_V_BP     = 33;

  localparam int PIXEL_COORD_W = 11;

  // Each channel is widened by repeating its bit pattern, so full scale maps
  // to 8'hFF and zero stays zero.
  // Result layout: {red[7:0], green[7:0], blue[7:0]}.
  function automatic logic [23:0] expand_rgb332(input logic [7:0] rgb);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = rgb[7:5];
    g = rgb[4:2];
    b = rgb[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : delay_line
// Purpose  : DEPTH-stage register pipeline with synchronous reset to a
//            parameterised value. DEPTH = 0 degenerates to a plain wire.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset (all stages <= RESET_VAL)
//            i_d  - data in  [WIDTH-1:0]
//            o_q  - data out [WIDTH-1:0], i_d delayed by DEPTH cycles
// Revision : 1.0 - initial release
// ============================================================================
module delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst;
      assign o_q = i_d;
    end else begin : g_regs
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= RESET_VAL;
          end
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA raster timing. Produces pixel coordinates for the drawing
//            objects, takes the resulting RRRGGGBB colour back, blanks it
//            outside the active area and expands it to 8 bits per channel.
//            Sync/blank are delayed to line up with the drawing pipeline.
// Ports    : clk          - pixel-domain clock
//            reset        - synchronous active-high reset
//            pixelX/Y     - raster counters (0..H_TOTAL-1 / 0..V_TOTAL-1)
//            pixelValid   - counters inside the active area
//            startOfFrame - one-clk pulse on entering (0,0) after a wrap
//            RGBIn        - RRRGGGBB colour, PIPE_DELAY clks after pixelX/Y
//            hSyncN/vSyncN- active-low syncs, aligned with colour outputs
//            blankN       - high while colour outputs are active
//            red/green/blue - expanded colour, zero while blanked
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import defines::*;
#(
  parameter int H_ACTIVE   = c_H_ACTIVE,
  parameter int H_FP       = c_H_FP,
  parameter int H_SYNC     = c_H_SYNC,
  parameter int H_BP       = c_H_BP,
  parameter int V_ACTIVE   = c_V_ACTIVE,
  parameter int V_FP       = c_V_FP,
  parameter int V_SYNC     = c_V_SYNC,
  parameter int V_BP       = c_V_BP,
  parameter int PIXEL_DIV  = 2,
  parameter int PIPE_DELAY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [PIXEL_COORD_W-1:0] pixelX,
  output logic [PIXEL_COORD_W-1:0] pixelY,
  output logic                     pixelValid,
  output logic                     startOfFrame,
  input  logic [7:0]               RGBIn,
  output logic                     hSyncN,
  output logic                     vSyncN,
  output logic                     blankN,
  output logic [7:0]               red,
  output logic [7:0]               green,
  output logic [7:0]               blue
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_div_w   = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

  localparam logic [PIXEL_COORD_W-1:0] c_h_last   = PIXEL_COORD_W'(c_h_total - 1);
  localparam logic [PIXEL_COORD_W-1:0] c_v_last   = PIXEL_COORD_W'(c_v_total - 1);
  localparam logic [PIXEL_COORD_W-1:0] c_h_act    = PIXEL_COORD_W'(H_ACTIVE);
  localparam logic [PIXEL_COORD_W-1:0] c_v_act    = PIXEL_COORD_W'(V_ACTIVE);
  localparam logic [PIXEL_COORD_W-1:0] c_hs_start = PIXEL_COORD_W'(H_ACTIVE + H_FP);
  localparam logic [PIXEL_COORD_W-1:0] c_hs_end   = PIXEL_COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [PIXEL_COORD_W-1:0] c_vs_start = PIXEL_COORD_W'(V_ACTIVE + V_FP);
  localparam logic [PIXEL_COORD_W-1:0] c_vs_end   = PIXEL_COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  // --------------------------------------------------------------------------
  // Pixel-rate divider. With PIXEL_DIV = 1 the counter is stuck at 0 and the
  // compare below is always true, so every clk is a tick.
  // --------------------------------------------------------------------------
  logic [c_div_w-1:0] r_div_cnt;
  logic               w_tick;

  assign w_tick = (r_div_cnt == c_div_w'(PIXEL_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + c_div_w'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Raster counters and start-of-frame pulse
  // --------------------------------------------------------------------------
  logic [PIXEL_COORD_W-1:0] r_h_cnt;
  logic [PIXEL_COORD_W-1:0] r_v_cnt;
  logic                     r_sof;
  logic                     w_h_end;
  logic                     w_v_end;

  assign w_h_end = (r_h_cnt == c_h_last);
  assign w_v_end = (r_v_cnt == c_v_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_sof   <= 1'b0;
    end else begin
      // Set on the same edge that wraps both counters, so the pulse covers
      // exactly the first clk spent at (0,0). Reset lands on (0,0) without
      // passing through here, hence no pulse after reset.
      r_sof <= w_tick && w_h_end && w_v_end;
      if (w_tick) begin
        if (w_h_end) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_end ? '0 : (r_v_cnt + PIXEL_COORD_W'(1));
        end else begin
          r_h_cnt <= r_h_cnt + PIXEL_COORD_W'(1);
        end
      end
    end
  end

  assign pixelX       = r_h_cnt;
  assign pixelY       = r_v_cnt;
  assign startOfFrame = r_sof;

  // --------------------------------------------------------------------------
  // Raw sync/valid, decoded straight from the counters
  // --------------------------------------------------------------------------
  logic w_valid;
  logic w_hsync_n;
  logic w_vsync_n;

  assign w_valid    = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
  assign pixelValid = w_valid;
  assign w_hsync_n  = !((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end));
  assign w_vsync_n  = !((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end));

  // --------------------------------------------------------------------------
  // Match the drawing pipeline latency. Reset value is the inactive pattern:
  // syncs high, valid low.
  // --------------------------------------------------------------------------
  logic [2:0] w_dly;

  delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (3'b110)
  ) u_sync_dly (
    .clk (clk),
    .rst (reset),
    .i_d ({w_hsync_n, w_vsync_n, w_valid}),
    .o_q (w_dly)
  );

  // --------------------------------------------------------------------------
  // Output register: colour from RGBIn and the delayed sync/valid are
  // captured on the same edge, keeping them aligned at the DAC.
  // --------------------------------------------------------------------------
  logic [23:0] w_rgb24;

  assign w_rgb24 = expand_rgb332(RGBIn);

  always_ff @(posedge clk) begin
    if (reset) begin
      hSyncN <= 1'b1;
      vSyncN <= 1'b1;
      blankN <= 1'b0;
      red    <= '0;
      green  <= '0;
      blue   <= '0;
    end else begin
      hSyncN <= w_dly[2];
      vSyncN <= w_dly[1];
      blankN <= w_dly[0];
      if (w_dly[0]) begin
        {red, green, blue} <= w_rgb24;
      end else begin
        {red, green, blue} <= '0;
      end
    end
  end

endmodule
`default_nettype wire
